// File: rtl/clk_ratio_ctrl.sv
// clk_ratio_ctrl: clock-enable scheduler for the slow datapath domain.
// Emits a one-cycle registered ce every cur_div system clocks, optionally
// stretching single periods by one cycle under LFSR control, and swaps the
// ratio through a RUN -> DRAIN -> SWITCH handshake at a period boundary.
module clk_ratio_ctrl #(
    parameter int unsigned DIV_W      = 3,
    parameter int unsigned RESET_DIV  = 2,
    parameter logic [7:0]  LFSR_RESET = 8'hA5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DIV_W-1:0] req_div,
    input  logic             req_jitter,
    input  logic             core_busy,
    input  logic             seed_load,
    input  logic [7:0]       seed,
    output logic             ce,
    output logic [DIV_W-1:0] cur_div,
    output logic             jitter_on,
    output logic             switching
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SWITCH = 2'd2
    } state_t;

    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic             stall;
    logic [7:0]       lfsr;
    logic [DIV_W-1:0] pend_div;
    logic             pend_jit;

    logic [DIV_W-1:0] eff_div;
    logic             eff_jit;
    logic             terminal;
    logic [DIV_W-1:0] cnt_nxt;
    logic             ce_nxt;
    logic             stall_nxt;
    logic             lfsr_fb;

    // Period counter next-state: wrap/pulse at terminal count, optional one-cycle stretch.
    // The SWITCH cycle acts as count position 0 of the new ratio (cnt is zeroed on
    // entry), so the first new-ratio ce lands exactly pend_div cycles after SWITCH.
    always_comb begin
        eff_div   = (state == SWITCH) ? pend_div : cur_div;
        eff_jit   = (state == SWITCH) ? pend_jit : jitter_on;
        terminal  = (cnt == eff_div - DIV_W'(1));
        cnt_nxt   = cnt + DIV_W'(1);
        ce_nxt    = 1'b0;
        stall_nxt = 1'b0;
        lfsr_fb   = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
        if (stall) begin
            cnt_nxt = '0;
            ce_nxt  = 1'b1;
        end else if (terminal) begin
            if (eff_jit && lfsr[0]) begin
                cnt_nxt   = cnt;
                stall_nxt = 1'b1;
            end else begin
                cnt_nxt = '0;
                ce_nxt  = 1'b1;
            end
        end
    end

    // Ratio-change FSM with registered outputs, LFSR and period counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            cnt       <= '0;
            stall     <= 1'b0;
            ce        <= 1'b0;
            lfsr      <= LFSR_RESET;
            cur_div   <= DIV_W'(RESET_DIV);
            jitter_on <= 1'b0;
            pend_div  <= '0;
            pend_jit  <= 1'b0;
            req_ready <= 1'b1;
            switching <= 1'b0;
        end else begin
            if (seed_load) begin
                lfsr <= (seed == 8'h00) ? 8'h01 : seed;
            end else begin
                lfsr <= {lfsr[6:0], lfsr_fb};
            end
            cnt   <= cnt_nxt;
            ce    <= ce_nxt;
            stall <= stall_nxt;
            case (state)
                RUN: begin
                    if (req_valid && req_ready) begin
                        pend_div  <= (req_div == '0) ? DIV_W'(1) : req_div;
                        pend_jit  <= req_jitter;
                        state     <= DRAIN;
                        req_ready <= 1'b0;
                        switching <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (ce && !core_busy) begin
                        state <= SWITCH;
                        cnt   <= '0;
                        stall <= 1'b0;
                        ce    <= 1'b0;
                    end
                end
                SWITCH: begin
                    cur_div   <= pend_div;
                    jitter_on <= pend_jit;
                    state     <= RUN;
                    req_ready <= 1'b1;
                    switching <= 1'b0;
                end
                default: begin
                    state     <= RUN;
                    req_ready <= 1'b1;
                    switching <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_ratio_ctrl.sv
// Directed bench for clk_ratio_ctrl: a cycle model predicts the outputs after
// every edge into a scoreboard queue, popped and checked 1 ns past the edge,
// plus directed checks on ratio, gaps and handshake flags.
module tb_clk_ratio_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_div;
    logic       req_jitter;
    logic       core_busy;
    logic       seed_load;
    logic [7:0] seed;
    logic       ce;
    logic [2:0] cur_div;
    logic       jitter_on;
    logic       switching;

    clk_ratio_ctrl #(
        .DIV_W      (3),
        .RESET_DIV  (2),
        .LFSR_RESET (8'hA5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_div    (req_div),
        .req_jitter (req_jitter),
        .core_busy  (core_busy),
        .seed_load  (seed_load),
        .seed       (seed),
        .ce         (ce),
        .cur_div    (cur_div),
        .jitter_on  (jitter_on),
        .switching  (switching)
    );

    always #5 clk = ~clk;

    // observed/expected vector: {ce, cur_div, jitter_on, req_ready, switching}
    logic [6:0] sb_q[$];

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    // reference model state
    int unsigned m_st;   // 0 RUN, 1 DRAIN, 2 SWITCH
    logic        m_ce;
    int unsigned m_ph;
    logic [2:0]  m_div;
    logic [2:0]  m_pdiv;
    logic        m_jit;
    logic        m_pjit;
    logic        m_ext;
    logic [7:0]  m_lfsr;

    // gap bookkeeping
    int unsigned cyc     = 0;
    int unsigned last_ce = 0;
    bit          have_last = 0;
    int unsigned last_gap  = 0;
    int unsigned gmin = 99;
    int unsigned gmax = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Predict outputs after the coming edge from the inputs now applied.
    task automatic model_step();
        logic [2:0]  d;
        logic        j;
        logic        nce;
        if (rst) begin
            m_st = 0; m_ce = 1'b0; m_ph = 0; m_div = 3'd2; m_jit = 1'b0;
            m_lfsr = 8'hA5; m_ext = 1'b0; m_pdiv = 3'd0; m_pjit = 1'b0;
        end else begin
            d   = (m_st == 2) ? m_pdiv : m_div;
            j   = (m_st == 2) ? m_pjit : m_jit;
            nce = 1'b0;
            if (m_ext) begin
                nce = 1'b1; m_ph = 0; m_ext = 1'b0;
            end else if (m_ph + 1 >= d) begin
                if (j && m_lfsr[0]) m_ext = 1'b1;
                else begin nce = 1'b1; m_ph = 0; end
            end else begin
                m_ph++;
            end
            if (seed_load) m_lfsr = (seed == 8'h00) ? 8'h01 : seed;
            else m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            case (m_st)
                0: if (req_valid) begin
                    m_pdiv = (req_div == 3'd0) ? 3'd1 : req_div;
                    m_pjit = req_jitter;
                    m_st   = 1;
                end
                1: if (m_ce && !core_busy) begin
                    m_st = 2; nce = 1'b0; m_ph = 0; m_ext = 1'b0;
                end
                default: begin
                    m_div = m_pdiv; m_jit = m_pjit; m_st = 0;
                end
            endcase
            m_ce = nce;
        end
        sb_q.push_back({m_ce, m_div, m_jit, (m_st == 0), (m_st != 0)});
    endtask

    // One clock: predict, clock, compare against the scoreboard, track ce gaps.
    task automatic tick();
        logic [6:0] exp;
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: observed 0 entries expected 1");
        end else begin
            exp = sb_q.pop_front();
            assert ({ce, cur_div, jitter_on, req_ready, switching} === exp) else begin
                n_fail++;
                $error("FAIL cycle_outputs @%0d: observed %h expected %h", cyc,
                       {ce, cur_div, jitter_on, req_ready, switching}, exp);
            end
        end
        if (ce === 1'b1) begin
            if (have_last) begin
                last_gap = cyc - last_ce;
                if (last_gap < gmin) gmin = last_gap;
                if (last_gap > gmax) gmax = last_gap;
            end
            have_last = 1;
            last_ce   = cyc;
        end
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic request(input logic [2:0] div, input logic jit);
        req_valid  = 1'b1;
        req_div    = div;
        req_jitter = jit;
        tick();
        req_valid  = 1'b0;
        req_jitter = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_div = 3'd0; req_jitter = 1'b0;
        core_busy = 1'b0; seed_load = 1'b0; seed = 8'h00;

        // reset defaults, no ce while rst is high
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_ce", ce, 0);
        end
        chk("rst_cur_div", cur_div, 2);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_switching", switching, 0);

        // release: ce in cycles 2, 4, 6, 8
        rst = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("reset_phase", ce, (i % 2 == 0));
        end

        // idle ratio change to 5
        request(3'd5, 1'b0);
        chk("accept_switching", switching, 1);
        chk("accept_req_ready", req_ready, 0);
        run(25);
        chk("ratio5_cur_div", cur_div, 5);
        chk("ratio5_gap", last_gap, 5);

        // switch blocked by busy for 20 cycles
        core_busy = 1'b1;
        request(3'd3, 1'b0);
        run(20);
        chk("busy_switching", switching, 1);
        chk("busy_req_ready", req_ready, 0);
        chk("busy_old_div", cur_div, 5);
        chk("busy_old_gap", last_gap, 5);
        core_busy = 1'b0;
        run(20);
        chk("ratio3_cur_div", cur_div, 3);
        chk("ratio3_gap", last_gap, 3);

        // ratio 0 behaves as 1, then 7
        request(3'd0, 1'b0);
        run(10);
        chk("ratio0_cur_div", cur_div, 1);
        chk("ratio0_ce_high", ce, 1);
        chk("ratio0_gap", last_gap, 1);
        request(3'd7, 1'b0);
        run(30);
        chk("ratio7_cur_div", cur_div, 7);
        chk("ratio7_gap", last_gap, 7);

        // jitter at ratio 4 from seed 3C
        seed_load = 1'b1; seed = 8'h3C;
        tick();
        seed_load = 1'b0;
        request(3'd4, 1'b1);
        run(40);
        chk("jit_on", jitter_on, 1);
        chk("jit_cur_div", cur_div, 4);
        gmin = 99; gmax = 0;
        run(200);
        chk("jit_gap_min", gmin, 4);
        chk("jit_gap_max", gmax, 5);

        // zero seed loads as 01
        seed_load = 1'b1; seed = 8'h00;
        tick();
        seed_load = 1'b0;
        gmin = 99; gmax = 0;
        run(60);
        chk("seed0_gap_min_ge4", (gmin >= 4), 1);
        chk("seed0_gap_max_le5", (gmax <= 5), 1);

        // back to plain ratio 2, then reset mid-DRAIN discards a request for 6
        request(3'd2, 1'b0);
        run(20);
        core_busy = 1'b1;
        request(3'd6, 1'b0);
        run(5);
        chk("drain_switching", switching, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstdrain_cur_div", cur_div, 2);
        chk("rstdrain_switching", switching, 0);
        chk("rstdrain_req_ready", req_ready, 1);
        chk("rstdrain_jitter_on", jitter_on, 0);
        core_busy = 1'b0;
        run(20);
        chk("rstdrain_no_switch", cur_div, 2);
        chk("rstdrain_gap", last_gap, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
